// File: rtl/control_unit_pkg.sv
// Shared definitions for the adding-machine control unit: opcodes, the halt
// address, FSM state encoding and the DataPath strobe bundle.
package control_unit_pkg;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [5:0] HLT_ADR = 6'h3F;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EX_LDA,
    S_EX_ADD,
    S_EX_STA,
    S_EX_JMP,
    S_HALT,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic load_IR;
    logic load_acc;
    logic sel_alu;
    logic sel_bus;
    logic pass_add;
    logic div_pass;
    logic ld_pc;
    logic clr_pc;
    logic inc_pc;
    logic ir_on_adr;
    logic pc_on_adr;
  } strobes_t;

  // States that hold a memory request open and are guarded by the wait timer.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_EX_LDA) || (s == S_EX_STA);
  endfunction

endpackage

// File: rtl/control_unit_mem_wait_timer.sv
// Memory-handshake watchdog: counts stalled cycles in a wait state and flags
// when the budget of MEM_TIMEOUT cycles has been used up.
module control_unit_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] r_wait_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_wait_cnt <= '0;
    end else if (i_count_en && !o_expired) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_expired = (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_unit.sv
// Sequencing FSM for the adding machine: fetches, decodes and executes
// LDA/ADD/STA/JMP/HLT and drives every DataPath control strobe.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [5:0]       ir_adr,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             load_IR,
  output logic             load_acc,
  output logic             sel_alu,
  output logic             sel_bus,
  output logic             pass_add,
  output logic             div_pass,
  output logic             ld_pc,
  output logic             clr_pc,
  output logic             inc_pc,
  output logic             ir_on_adr,
  output logic             pc_on_adr,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  strobes_t         w_strb;
  logic             w_retire;
  logic             w_in_wait;
  logic             w_expired;
  logic [CNT_W-1:0] r_instr_count;

  assign w_in_wait = is_mem_wait(r_state);

  // Any completion leaves the wait state, so mem_ready doubles as the clear.
  control_unit_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_in_wait || mem_ready),
    .i_count_en(w_in_wait && !mem_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    w_strb   = '0;
    w_retire = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_strb.clr_pc = 1'b1;
        if (start) w_next = S_FETCH;
      end

      S_FETCH: begin
        w_strb.pc_on_adr = 1'b1;
        w_strb.mem_rd    = 1'b1;
        if (mem_ready) begin
          w_strb.sel_bus = 1'b1;
          w_strb.load_IR = 1'b1;
          w_strb.inc_pc  = 1'b1;
          w_next         = S_DECODE;
        end else if (w_expired) begin
          w_next = S_ERROR;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_LDA: w_next = S_EX_LDA;
          OP_ADD: w_next = S_EX_ADD;
          OP_STA: w_next = S_EX_STA;
          default: begin
            if (ir_adr == HLT_ADR) begin
              w_next   = S_HALT;
              w_retire = 1'b1;
            end else begin
              w_next = S_EX_JMP;
            end
          end
        endcase
      end

      S_EX_LDA: begin
        w_strb.ir_on_adr = 1'b1;
        w_strb.mem_rd    = 1'b1;
        if (mem_ready) begin
          w_strb.sel_bus  = 1'b1;
          w_strb.load_acc = 1'b1;
          w_retire        = 1'b1;
          w_next          = S_FETCH;
        end else if (w_expired) begin
          w_next = S_ERROR;
        end
      end

      S_EX_ADD: begin
        w_strb.sel_alu  = 1'b1;
        w_strb.pass_add = 1'b1;
        w_strb.load_acc = 1'b1;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end

      S_EX_STA: begin
        // ALU passes the accumulator through onto Data_bus_out.
        w_strb.ir_on_adr = 1'b1;
        w_strb.mem_wr    = 1'b1;
        w_strb.sel_alu   = 1'b1;
        w_strb.div_pass  = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_expired) begin
          w_next = S_ERROR;
        end
      end

      S_EX_JMP: begin
        w_strb.ld_pc = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end

      S_HALT:  w_next = S_HALT;
      S_ERROR: w_next = S_ERROR;

      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_retire && (r_instr_count != {CNT_W{1'b1}})) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  // Requests fall in the reset cycle itself rather than one edge later.
  assign mem_rd    = w_strb.mem_rd & ~reset;
  assign mem_wr    = w_strb.mem_wr & ~reset;
  assign load_IR   = w_strb.load_IR;
  assign load_acc  = w_strb.load_acc;
  assign sel_alu   = w_strb.sel_alu;
  assign sel_bus   = w_strb.sel_bus;
  assign pass_add  = w_strb.pass_add;
  assign div_pass  = w_strb.div_pass;
  assign ld_pc     = w_strb.ld_pc;
  assign clr_pc    = w_strb.clr_pc;
  assign inc_pc    = w_strb.inc_pc;
  assign ir_on_adr = w_strb.ir_on_adr;
  assign pc_on_adr = w_strb.pc_on_adr;

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERROR);
  assign halted      = (r_state == S_HALT);
  assign error       = (r_state == S_ERROR);
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a tiny PC/IR/memory model feeds the FSM,
// and a scoreboard of per-cycle expected strobe vectors is drained against it.
module tb_control_unit;

  localparam int MEM_TIMEOUT = 4;

  // Strobe vector bit weights: {mem_rd,mem_wr,load_IR,load_acc,sel_alu,sel_bus,
  // pass_add,div_pass,ld_pc,clr_pc,inc_pc,ir_on_adr,pc_on_adr,busy,halted,error}
  localparam logic [15:0] B_RD   = 16'h8000;
  localparam logic [15:0] B_WR   = 16'h4000;
  localparam logic [15:0] B_LIR  = 16'h2000;
  localparam logic [15:0] B_LACC = 16'h1000;
  localparam logic [15:0] B_ALU  = 16'h0800;
  localparam logic [15:0] B_BUS  = 16'h0400;
  localparam logic [15:0] B_ADD  = 16'h0200;
  localparam logic [15:0] B_DIV  = 16'h0100;
  localparam logic [15:0] B_LDPC = 16'h0080;
  localparam logic [15:0] B_CLR  = 16'h0040;
  localparam logic [15:0] B_INC  = 16'h0020;
  localparam logic [15:0] B_IRA  = 16'h0010;
  localparam logic [15:0] B_PCA  = 16'h0008;
  localparam logic [15:0] B_BUSY = 16'h0004;
  localparam logic [15:0] B_HALT = 16'h0002;
  localparam logic [15:0] B_ERR  = 16'h0001;

  localparam logic [15:0] V_IDLE   = B_CLR;
  localparam logic [15:0] V_FWAIT  = B_PCA | B_RD | B_BUSY;
  localparam logic [15:0] V_FDONE  = V_FWAIT | B_BUS | B_LIR | B_INC;
  localparam logic [15:0] V_DEC    = B_BUSY;
  localparam logic [15:0] V_LWAIT  = B_IRA | B_RD | B_BUSY;
  localparam logic [15:0] V_LDONE  = V_LWAIT | B_BUS | B_LACC;
  localparam logic [15:0] V_ADD    = B_ALU | B_ADD | B_LACC | B_BUSY;
  localparam logic [15:0] V_STA    = B_IRA | B_WR | B_ALU | B_DIV | B_BUSY;
  localparam logic [15:0] V_JMP    = B_LDPC | B_BUSY;
  localparam logic [15:0] V_HALT   = B_HALT;
  localparam logic [15:0] V_ERROR  = B_ERR;

  logic        clock, reset, start, mem_ready;
  logic [1:0]  opcode;
  logic [5:0]  ir_adr;
  logic        mem_rd, mem_wr, load_IR, load_acc, sel_alu, sel_bus, pass_add, div_pass;
  logic        ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr, busy, halted, error;
  logic [15:0] instr_count;

  logic        s_rd, s_wr, s_lir, s_lacc, s_alu, s_bus, s_add, s_div;
  logic        s_ldpc, s_clr, s_inc, s_ira, s_pca, s_busy, s_halt, s_err;
  logic [1:0]  s_count;

  logic [7:0]  mem [64];
  logic [5:0]  m_pc;
  logic [7:0]  m_ir;
  logic [15:0] vec;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        st;
    logic        rdy;
    logic [15:0] exp;
    string       tag;
  } step_t;

  step_t sb_q[$];

  control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .ir_adr(ir_adr),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_IR(load_IR),
    .load_acc(load_acc), .sel_alu(sel_alu), .sel_bus(sel_bus), .pass_add(pass_add),
    .div_pass(div_pass), .ld_pc(ld_pc), .clr_pc(clr_pc), .inc_pc(inc_pc),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .busy(busy), .halted(halted),
    .error(error), .instr_count(instr_count)
  );

  // Narrow-counter twin in lockstep, used only to observe count saturation.
  control_unit #(.MEM_TIMEOUT(16), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .ir_adr(ir_adr),
    .mem_ready(mem_ready), .mem_rd(s_rd), .mem_wr(s_wr), .load_IR(s_lir),
    .load_acc(s_lacc), .sel_alu(s_alu), .sel_bus(s_bus), .pass_add(s_add),
    .div_pass(s_div), .ld_pc(s_ldpc), .clr_pc(s_clr), .inc_pc(s_inc),
    .ir_on_adr(s_ira), .pc_on_adr(s_pca), .busy(s_busy), .halted(s_halt),
    .error(s_err), .instr_count(s_count)
  );

  assign vec = {mem_rd, mem_wr, load_IR, load_acc, sel_alu, sel_bus, pass_add, div_pass,
                ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr, busy, halted, error};
  assign opcode = m_ir[7:6];
  assign ir_adr = m_ir[5:0];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Minimal DataPath stand-in: PC and IR react to the DUT strobes.
  always @(posedge clock) begin
    if (load_IR) m_ir <= mem[m_pc];
    if (clr_pc)      m_pc <= 6'd0;
    else if (ld_pc)  m_pc <= m_ir[5:0];
    else if (inc_pc) m_pc <= m_pc + 6'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic st, input logic rdy, input logic [15:0] exp);
    step_t e;
    e.st  = st;
    e.rdy = rdy;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic run_steps();
    step_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clock);
      start     = e.st;
      mem_ready = e.rdy;
      #1;
      check(e.tag, {16'd0, vec}, {16'd0, e.exp});
    end
    @(negedge clock);
    start     = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset     = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check({tag, "_vec"}, {16'd0, vec}, {16'd0, V_IDLE});
    check({tag, "_cnt"}, {16'd0, instr_count}, 32'd0);
  endtask

  task automatic load_prog(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p4, input logic [7:0] p5);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[4] = p4; mem[5] = p5;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    m_ir      = 8'h00;
    m_pc      = 6'd0;

    // ADD 5, ADD 3, HLT with zero-wait memory.
    load_prog(8'b01_000101, 8'b01_000011, 8'b11_111111, 8'h00, 8'h00);
    do_reset("t1_rst");
    push("t1_idle", 1, 1, V_IDLE);
    push("t1_f0",   0, 1, V_FDONE);
    push("t1_d0",   0, 1, V_DEC);
    push("t1_add0", 0, 1, V_ADD);
    push("t1_f1",   0, 1, V_FDONE);
    push("t1_d1",   0, 1, V_DEC);
    push("t1_add1", 0, 1, V_ADD);
    push("t1_f2",   0, 1, V_FDONE);
    push("t1_d2",   0, 1, V_DEC);
    push("t1_halt", 0, 1, V_HALT);
    push("t1_halt_start", 1, 1, V_HALT);
    push("t1_halt_stay",  0, 0, V_HALT);
    run_steps();
    check("t1_count", {16'd0, instr_count}, 32'd3);
    check("t1_sat_count", {30'd0, s_count}, 32'd3);

    // FETCH stalls three cycles; completion lands exactly on the timeout boundary.
    load_prog(8'b11_111111, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset("t2_rst");
    push("t2_idle",  1, 0, V_IDLE);
    push("t2_fw0",   0, 0, V_FWAIT);
    push("t2_fw1",   0, 0, V_FWAIT);
    push("t2_fw2",   0, 0, V_FWAIT);
    push("t2_fdone", 0, 1, V_FDONE);
    push("t2_dec",   0, 1, V_DEC);
    push("t2_halt",  0, 0, V_HALT);
    run_steps();
    check("t2_count", {16'd0, instr_count}, 32'd1);

    // LDA 0A, STA 0B, JMP 04, (04) ADD 1, HLT.
    load_prog(8'b00_001010, 8'b10_001011, 8'b11_000100, 8'b01_000001, 8'b11_111111);
    do_reset("t3_rst");
    push("t3_idle", 1, 1, V_IDLE);
    push("t3_f0",   0, 1, V_FDONE);
    push("t3_d0",   0, 1, V_DEC);
    push("t3_lda",  0, 1, V_LDONE);
    push("t3_f1",   0, 1, V_FDONE);
    push("t3_d1",   0, 1, V_DEC);
    push("t3_sta",  0, 1, V_STA);
    push("t3_f2",   0, 1, V_FDONE);
    push("t3_d2",   0, 1, V_DEC);
    push("t3_jmp",  0, 1, V_JMP);
    push("t3_f4",   0, 1, V_FDONE);
    push("t3_d4",   0, 1, V_DEC);
    push("t3_add",  0, 1, V_ADD);
    push("t3_f5",   0, 1, V_FDONE);
    push("t3_d5",   0, 1, V_DEC);
    push("t3_halt", 0, 1, V_HALT);
    run_steps();
    check("t3_count", {16'd0, instr_count}, 32'd5);
    check("t3_sat_count", {30'd0, s_count}, 32'd3);
    check("t3_pc", {26'd0, m_pc}, 32'd6);

    // Memory never answers an LDA: four wait cycles then sticky ERROR.
    load_prog(8'b00_001010, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset("t5_rst");
    push("t5_idle", 1, 1, V_IDLE);
    push("t5_f0",   0, 1, V_FDONE);
    push("t5_d0",   0, 0, V_DEC);
    push("t5_lw0",  0, 0, V_LWAIT);
    push("t5_lw1",  0, 0, V_LWAIT);
    push("t5_lw2",  0, 0, V_LWAIT);
    push("t5_lw3",  0, 0, V_LWAIT);
    push("t5_err0", 0, 0, V_ERROR);
    push("t5_err_start", 1, 1, V_ERROR);
    push("t5_err_stay",  0, 1, V_ERROR);
    run_steps();
    check("t5_count", {16'd0, instr_count}, 32'd0);
    do_reset("t5_recover");

    // Reset lands while an STA write is still waiting for memory.
    load_prog(8'b00_001010, 8'b10_001011, 8'h00, 8'h00, 8'h00);
    do_reset("t6_rst");
    push("t6_idle", 1, 1, V_IDLE);
    push("t6_f0",   0, 1, V_FDONE);
    push("t6_d0",   0, 1, V_DEC);
    push("t6_lda",  0, 1, V_LDONE);
    push("t6_f1",   0, 1, V_FDONE);
    push("t6_d1",   0, 0, V_DEC);
    push("t6_sw0",  0, 0, V_STA);
    push("t6_sw1",  0, 0, V_STA);
    sb_q.push_back('{st: 1'b0, rdy: 1'b0, exp: V_STA, tag: "t6_sw2"});
    run_steps();
    check("t6_pre_count", {16'd0, instr_count}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_wr_drop", {31'd0, mem_wr}, 32'd0);
    @(negedge clock);
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_vec", {16'd0, vec}, {16'd0, V_IDLE});
    check("t6_count", {16'd0, instr_count}, 32'd0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
